// File: rtl/ble_tx_pkg.sv
// ble_tx_pkg: shared state type and header constants for the BLE TX path
package ble_tx_pkg;
  localparam int PREAMBLE_BITS = 8;
  localparam int AA_BITS = 32;
  localparam logic [7:0] PREAMBLE_AA_LSB1 = 8'h55;
  localparam logic [7:0] PREAMBLE_AA_LSB0 = 8'hAA;
  typedef enum logic [2:0] {IDLE, RESTART, PREAMBLE, ADDR, PDU, DRAIN} wseq_state_t;
  function automatic logic [7:0] preamble_for(input logic aa_lsb);
    return aa_lsb ? PREAMBLE_AA_LSB1 : PREAMBLE_AA_LSB0;
  endfunction
endpackage

// File: rtl/header_shifter.sv
// header_shifter: LSB-first preamble+address shift register with a per-field bit counter
module header_shifter #(
  parameter int W = 40,
  parameter int CW = 6
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          load,
  input  logic [W-1:0]  din,
  input  logic          shift,
  input  logic [CW-1:0] last_idx,
  output logic          bit_out,
  output logic          last
);
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  assign bit_out = sr[0];
  assign last = cnt == last_idx;
  // load clears the counter; it wraps at each field end so the next field counts from 0
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      sr <= '0;
      cnt <= '0;
    end else if (load) begin
      sr <= din;
      cnt <= '0;
    end else if (shift) begin
      sr <= sr >> 1;
      cnt <= last ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/whitening_sequencer.sv
// whitening_sequencer: per-packet restart, bypassed header, whitened PDU and drain control for the BLE whitener
module whitening_sequencer import ble_tx_pkg::*; #(
  parameter int AA_BITS = 32,
  parameter int PREAMBLE_BITS = 8
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic [5:0]         channel,
  input  logic [AA_BITS-1:0] access_address,
  output logic               busy,
  output logic               done,
  input  logic               pdu_tdata,
  input  logic               pdu_tvalid,
  input  logic               pdu_tlast,
  output logic               pdu_tready,
  output logic               wht_tdata,
  output logic               wht_tvalid,
  output logic               wht_tlast,
  input  logic               wht_tready,
  output logic               wht_bypass,
  output logic               wht_restart,
  output logic [5:0]         wht_channel
);
  localparam int HW = AA_BITS + PREAMBLE_BITS;
  localparam int CW = $clog2(HW + 1);
  wseq_state_t state, state_nx;
  logic [5:0] ch_q;
  logic [AA_BITS-1:0] aa_q;
  logic hdr, pdu, hdr_bit, hdr_last, hdr_shift;
  assign wht_channel = ch_q;
  // state register; packet parameters captured only when a start is accepted
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state <= IDLE;
      ch_q <= '0;
      aa_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        ch_q <= channel;
        aa_q <= access_address;
      end
    end
  header_shifter #(.W(HW), .CW(CW)) u_hdr (
    .aclk     (aclk),
    .areset   (areset),
    .load     (state == RESTART),
    .din      ({aa_q, preamble_for(aa_q[0])}),
    .shift    (hdr_shift),
    .last_idx (state == ADDR ? CW'(AA_BITS - 1) : CW'(PREAMBLE_BITS - 1)),
    .bit_out  (hdr_bit),
    .last     (hdr_last)
  );
  // output muxing per state and next-state; bypass stays low through DRAIN until the held bit leaves
  always_comb begin
    hdr = state == PREAMBLE || state == ADDR;
    pdu = state == PDU;
    busy = state != IDLE;
    wht_restart = state == RESTART;
    wht_bypass = !(pdu || state == DRAIN);
    wht_tvalid = hdr ? 1'b1 : pdu ? pdu_tvalid : 1'b0;
    wht_tdata = hdr ? hdr_bit : pdu ? pdu_tdata : 1'b0;
    wht_tlast = pdu & pdu_tlast;
    pdu_tready = pdu & wht_tready;
    hdr_shift = hdr & wht_tready;
    done = state == DRAIN && wht_tready;
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = RESTART;
      RESTART:  state_nx = PREAMBLE;
      PREAMBLE: if (hdr_shift && hdr_last) state_nx = ADDR;
      ADDR:     if (hdr_shift && hdr_last) state_nx = PDU;
      PDU:      if (pdu_tvalid && wht_tready && pdu_tlast) state_nx = DRAIN;
      DRAIN:    if (wht_tready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
endmodule

// File: doc/whitening_sequencer.md
# whitening_sequencer

Packet-level controller for the BLE TX whitener. It sits between the PDU/CRC bit source and the whitening block. On each packet it restarts the whitener with the packet's channel and emits the 8-bit preamble and 32-bit access address with whitening bypassed. It then streams the PDU+CRC bits through the whitener un-bypassed, and drains the whitener before returning to bypass.

## Interface

Parameters
- `AA_BITS`, 32: access-address length in bits.
- `PREAMBLE_BITS`, 8: preamble length in bits.

Ports
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `channel`  in  6  physical channel index; latched on accepted `start`.
- `access_address`  in  32  latched on accepted `start`; transmitted LSB first.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the packet has fully left the whitener.
- `pdu_tdata`, `pdu_tvalid`, `pdu_tlast`  in  1 each  PDU+CRC bit stream.
- `pdu_tready`  out  1  handshake back to the PDU source.
- `wht_tdata`, `wht_tvalid`, `wht_tlast`  out  1 each  bit stream to the whitener input.
- `wht_tready`  in  1  whitener `input_tready`.
- `wht_bypass`  out  1  drives whitener `bypass`.
- `wht_restart`  out  1  drives whitener `restart`.
- `wht_channel`  out  6  drives whitener `channel`; held stable for the whole packet.

## Operation

- States: IDLE, RESTART, PREAMBLE, ADDR, PDU, DRAIN.
- **IDLE**
  - `wht_bypass`=1, `wht_tvalid`=0, `pdu_tready`=0.
  - On `start`: latch `channel` and `access_address`, go to RESTART.
- **RESTART** (exactly 1 cycle)
  - `wht_restart`=1, `wht_bypass`=1, `wht_channel`=latched channel.
  - Load the header shift register: preamble byte in bits [7:0], address above it.
  - Preamble byte is 8'h55 if AA[0]=1, otherwise 8'hAA, so the last preamble bit differs from the first AA bit.
- **PREAMBLE / ADDR**
  - `wht_bypass`=1, `wht_tvalid`=1, `wht_tdata`=shift[0], `wht_tlast`=0.
  - Shift and count on `wht_tvalid & wht_tready`.
  - After 8 handshakes go to ADDR; after 32 more go to PDU.
- **PDU**
  - `wht_bypass`=0.
  - Combinational pass-through: `wht_tdata`=`pdu_tdata`, `wht_tvalid`=`pdu_tvalid`, `wht_tlast`=`pdu_tlast`, `pdu_tready`=`wht_tready`.
  - A handshake with `pdu_tlast`=1 moves the FSM to DRAIN.
- **DRAIN**
  - `wht_bypass`=0, `wht_tvalid`=0, `pdu_tready`=0.
  - Wait for `wht_tready`=1; this signals the whitener has delivered its held last bit.
  - Then pulse `done` and go to IDLE, where bypass returns to 1.
  - Bypass must never rise while the whitener holds an undelivered bit.
- Header bit counter: 6 bits, wide enough for 40 and saturating nowhere; it is reset to 0 on entering PREAMBLE and on entering ADDR.
- `start` outside IDLE is ignored; there is no queueing.
- The PDU length is unbounded; only `pdu_tlast` ends the packet.

## Timing

- Reset values:
  - state=IDLE, `busy`=0, `done`=0.
  - `wht_bypass`=1, `wht_restart`=0.
  - `wht_tvalid`=0, `wht_tdata`=0, `wht_tlast`=0.
  - `pdu_tready`=0, `wht_channel`=0.
- `areset` mid-packet returns the block to IDLE immediately, with no `done`. The whitener is restarted on the next packet.
- Latency:
  - `start` at edge N: RESTART during cycle N+1.
  - First preamble bit valid in cycle N+2.
  - With `wht_tready` held at 1, the header takes 40 cycles and PDU is entered in cycle N+42.
- In PDU the whitener accepts at most 1 bit per 2 cycles; the sequencer imposes no additional bubbles.
- `done` is asserted in the cycle DRAIN observes `wht_tready`=1. `busy` falls in the following cycle.
- `wht_restart` never coincides with `wht_tvalid`=1.

## Structure

- Package `ble_tx_pkg`:
  - state enum `wseq_state_t`.
  - constants `PREAMBLE_BITS`, `AA_BITS`, `PREAMBLE_AA_LSB1`=8'h55, `PREAMBLE_AA_LSB0`=8'hAA.
- One sub-module, `header_shifter`: a 40-bit load/shift register with its bit counter and a `last` flag. The FSM and PDU muxing stay in the top.

## Test plan

- **Advertising header:** AA=32'h8E89BED6, channel=37, `wht_tready`=1.
  - `wht_restart` for 1 cycle with `wht_channel`=37.
  - Emitted bits: 0,1,0,1,0,1,0,1, then D6 LSB first (0,1,1,0,1,0,1,1…).
  - `wht_bypass`=1 throughout all 40 bits.
- **Preamble select:** AA=32'h00000001 -> preamble bits 1,0,1,0,1,0,1,0; the last preamble bit (0) differs from AA[0] (1).
- **PDU through whitener:** 16 zero bits, last tagged, with a reference whitener model attached.
  - Outputs equal the channel-37 LFSR sequence.
  - `wht_tlast` accompanies bit 16.
  - `done` pulses only after the whitener output handshake; `wht_bypass` stays 0 until then.
- **Backpressure:** `wht_tready` toggled randomly during the header -> no bit dropped or duplicated, and `wht_tdata` is stable while stalled.
- **Ignored start / reset:**
  - `start` pulsed during ADDR -> no effect.
  - `areset` during PDU -> all outputs at reset values asynchronously, no `done`, and the next `start` produces a full, correct packet.
